mag_peak_find: RTL and testbench
================================

# mag_peak_find

Streaming arg-max search over a fixed window of `mag_t` samples. Its input is the registered `|gamma|` stream from the AMBM magnitude stage. After a `start` pulse it watches the next `WIN_LEN` valid samples. It then reports the largest magnitude and that sample's index in the window, which the symbol-timing logic uses as the CP-correlation peak.

## Interface
Parameters:
- `WIN_LEN`, default 64: number of valid samples per search window; must be ≥ 2.
- `IDX_W`, default `$clog2(WIN_LEN)`: width of the index and counter.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: reset, synchronous and active-low (asserted when 0).
- `start`, in, 1: one-cycle request to begin a window; ignored unless the state is IDLE.
- `mag_valid`, in, 1: qualifies `mag_in`; gaps are allowed.
- `mag_in`, in, `MAG_W` (`mag_t`): magnitude sample, compared as unsigned.
- `busy`, out, 1: high in SEARCH and DONE.
- `peak_valid`, out, 1: one-cycle pulse when a result is ready.
- `peak_mag`, out, `MAG_W`: largest sample of the last completed window.
- `peak_idx`, out, `IDX_W`: 0-based window position of `peak_mag`.
- `peak_det`, out, 1: present only with `MAG_PEAK_THR_EN`.
- `thr`, in, `MAG_W`: present only with `MAG_PEAK_THR_EN`.

## Operation
- FSM has three states: IDLE, SEARCH, DONE.
  - IDLE → SEARCH on `start`=1.
  - SEARCH → DONE on acceptance of the `WIN_LEN`-th valid sample.
  - DONE → IDLE unconditionally after one cycle.
- The sample counter `cnt` counts only samples with `mag_valid`=1 while in SEARCH.
- A sample that arrives in the same cycle as `start` (state IDLE) is not part of the window.
- First window sample (`cnt`==0): loaded into the running max and index unconditionally, so an all-zero window gives `peak_idx`=0.
- Later samples replace the running max only if `mag_in` > running max (strictly greater). On ties the earliest index wins.
- `start` in SEARCH or DONE is ignored. There is no queuing and no restart.
- `peak_mag`, `peak_idx` and `peak_det` update only on entry to DONE. They hold until the next window completes.
- Reset mid-window discards the partial result and returns to IDLE.

## Timing
- Reset values: state IDLE, `cnt`=0, `busy`=0, `peak_valid`=0, `peak_mag`=0, `peak_idx`=0, `peak_det`=0.
- `busy` rises the cycle after the accepted `start`.
- Latency: the last window sample is accepted at edge N; `peak_valid`=1 and the results are valid in cycle N+1, for exactly one cycle.
- `busy` falls in the cycle after `peak_valid`.
  - The earliest next `start` that is accepted is the one presented in the `peak_valid` cycle? No: in that cycle the state is DONE, so that `start` is ignored. The earliest accepted `start` is in the first IDLE cycle after DONE.
- Minimum window duration is `WIN_LEN`+2 cycles from `start` to IDLE, with back-to-back valid samples.
- Counter wraps to 0 on the last sample. No over-count is possible.

## Configuration
- `MAG_PEAK_THR_EN` defined:
  - Adds the `thr` input and the `peak_det` output.
  - `peak_det` = (final `peak_mag` ≥ `thr`), compared unsigned.
  - `thr` is sampled on the DONE-entry edge.
- `MAG_PEAK_THR_EN` undefined: neither port exists, and there is no comparator logic.

## Structure
- Shared package `data_type`: add the enum `mag_peak_state_t` (IDLE, SEARCH, DONE). Reuse the existing `mag_t` and `MAG_W`.
- `IDX_W` stays a module parameter because it depends on `WIN_LEN`.
- Single flat module; no sub-module is warranted.

## Test plan
All scenarios use `WIN_LEN`=8.
1. Basic peak:
   - Stimulus: `start`, then contiguous samples 3,9,4,20,7,1,0,5.
   - Required: `peak_valid` one cycle after the 8th sample, with `peak_mag`=20 and `peak_idx`=3.
2. Tie and gaps:
   - Stimulus: samples 5,12,12,2,12,0,1,3, with `mag_valid` low for 2 cycles between each sample.
   - Required: `peak_idx`=1 and `peak_mag`=12.
   - Required: `peak_valid` exactly once, and `busy` high throughout.
3. Start collision and ignore:
   - Stimulus: `mag_valid`=1 with value 99 in the same cycle as `start`, then 8 samples all equal to 1.
   - Required: `peak_mag`=1 and `peak_idx`=0.
   - Stimulus: a second `start` mid-window.
   - Required: no effect.
4. Reset mid-window:
   - Stimulus: assert `rst`=0 after 4 samples, release it, then issue a new `start` and samples 0..7.
   - Required: all outputs 0 during reset, then `peak_mag`=7 and `peak_idx`=7.
5. Threshold (`MAG_PEAK_THR_EN`), with `thr`=10:
   - Window max 9 → `peak_det`=0.
   - Window max 10 → `peak_det`=1.
   - Without the macro, the design elaborates with no `thr` or `peak_det` ports.
6. All-zero window:
   - Required: `peak_mag`=0 and `peak_idx`=0.
   - Required: a back-to-back `start` presented in the `peak_valid` cycle is ignored.
   - Required: a `start` one cycle later is accepted.

Source files
------------

// File: rtl/data_type.sv
// Shared data types for the receiver datapath: magnitude sample type and
// the state encoding of the arg-max peak finder.
package data_type;

   localparam int MAG_W = 16;

   typedef logic [MAG_W-1:0] mag_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } mag_peak_state_t;

endpackage

// File: rtl/mag_peak_find.sv
// Streaming arg-max over a window of WIN_LEN valid magnitude samples.
// Optional threshold detect (thr / peak_det) is built when MAG_PEAK_THR_EN is defined.
module mag_peak_find
   import data_type::*;
#(
   parameter int WIN_LEN = 64,
   parameter int IDX_W   = $clog2(WIN_LEN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mag_valid,
   input  mag_t             mag_in,
`ifdef MAG_PEAK_THR_EN
   input  mag_t             thr,
   output logic             peak_det,
`endif
   output logic             busy,
   output logic             peak_valid,
   output mag_t             peak_mag,
   output logic [IDX_W-1:0] peak_idx
);

   mag_peak_state_t  r_state;
   mag_peak_state_t  w_state_next;
   logic [IDX_W-1:0] r_cnt;
   mag_t             r_max;
   logic [IDX_W-1:0] r_max_idx;

   logic             w_accept;
   logic             w_last;
   logic             w_take;
   mag_t             w_cand_mag;
   logic [IDX_W-1:0] w_cand_idx;

   assign w_accept = (r_state == SEARCH) && mag_valid;
   assign w_last   = w_accept && (r_cnt == IDX_W'(WIN_LEN - 1));
   // First sample always loads; later ones need to be strictly larger so ties keep the earliest index.
   assign w_take     = (r_cnt == '0) || (mag_in > r_max);
   assign w_cand_mag = w_take ? mag_in : r_max;
   assign w_cand_idx = w_take ? r_cnt  : r_max_idx;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = SEARCH;
         SEARCH:  if (w_last) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_max     <= '0;
         r_max_idx <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_cnt     <= w_last ? '0 : r_cnt + IDX_W'(1);
            r_max     <= w_cand_mag;
            r_max_idx <= w_cand_idx;
         end
      end
   end

   // Published results change only on the edge that enters DONE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         peak_mag <= '0;
         peak_idx <= '0;
      end else if (w_last) begin
         peak_mag <= w_cand_mag;
         peak_idx <= w_cand_idx;
      end
   end

`ifdef MAG_PEAK_THR_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         peak_det <= 1'b0;
      end else if (w_last) begin
         peak_det <= (w_cand_mag >= thr);
      end
   end
`endif

   assign busy       = (r_state != IDLE);
   assign peak_valid = (r_state == DONE);

endmodule

// File: tb/tb_mag_peak_find.sv
// Directed self-checking bench for mag_peak_find with WIN_LEN=8.
// Threshold checks are active when MAG_PEAK_THR_EN is defined.
module tb_mag_peak_find;
   import data_type::*;

   localparam int WIN_LEN = 8;
   localparam int IDX_W   = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             mag_valid;
   mag_t             mag_in;
   logic             busy;
   logic             peak_valid;
   mag_t             peak_mag;
   logic [IDX_W-1:0] peak_idx;
`ifdef MAG_PEAK_THR_EN
   mag_t             thr;
   logic             peak_det;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mag_peak_find #(.WIN_LEN(WIN_LEN), .IDX_W(IDX_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .mag_valid  (mag_valid),
      .mag_in     (mag_in),
`ifdef MAG_PEAK_THR_EN
      .thr        (thr),
      .peak_det   (peak_det),
`endif
      .busy       (busy),
      .peak_valid (peak_valid),
      .peak_mag   (peak_mag),
      .peak_idx   (peak_idx)
   );

   typedef struct {
      logic [0:7][15:0] s;
      int               gap;
      bit               collide;
      bit               mid_start;
      logic [15:0]      exp_mag;
      logic [2:0]       exp_idx;
      bit               exp_det;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one window; returns positioned in the peak_valid (DONE) cycle.
   task automatic run_window(input vec_t v, input int id, input bit do_start);
      if (do_start) begin
         start     = 1'b1;
         mag_valid = v.collide;
         mag_in    = 16'd99;
         tick();
         start     = 1'b0;
         mag_valid = 1'b0;
         chk("busy_rise", 32'(busy), 32'd1);
      end
      for (int i = 0; i < WIN_LEN; i++) begin
         mag_valid = 1'b1;
         mag_in    = v.s[i];
         start     = v.mid_start && (i == 4);
         tick();
         mag_valid = 1'b0;
         start     = 1'b0;
         if (i < WIN_LEN - 1) begin
            chk("no_early_valid", 32'(peak_valid), 32'd0);
            chk("busy_in_window", 32'(busy), 32'd1);
            for (int g = 0; g < v.gap; g++) begin
               tick();
               chk("gap_no_valid", 32'(peak_valid), 32'd0);
               chk("gap_busy", 32'(busy), 32'd1);
            end
         end
      end
      chk("peak_valid", 32'(peak_valid), 32'd1);
      chk("busy_done", 32'(busy), 32'd1);
      chk("peak_mag", 32'(peak_mag), 32'(v.exp_mag));
      chk("peak_idx", 32'(peak_idx), 32'(v.exp_idx));
`ifdef MAG_PEAK_THR_EN
      chk("peak_det", 32'(peak_det), 32'(v.exp_det));
`endif
      $display("window %0d: peak_mag=%0d peak_idx=%0d (exp %0d/%0d)",
               id, peak_mag, peak_idx, v.exp_mag, v.exp_idx);
   endtask

   task automatic finish_window();
      tick();
      chk("valid_one_cycle", 32'(peak_valid), 32'd0);
      chk("busy_fall", 32'(busy), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_peak_valid"}, 32'(peak_valid), 32'd0);
      chk({tag, "_peak_mag"}, 32'(peak_mag), 32'd0);
      chk({tag, "_peak_idx"}, 32'(peak_idx), 32'd0);
`ifdef MAG_PEAK_THR_EN
      chk({tag, "_peak_det"}, 32'(peak_det), 32'd0);
`endif
   endtask

   initial begin
      vecs[0] = '{s: {16'd3, 16'd9, 16'd4, 16'd20, 16'd7, 16'd1, 16'd0, 16'd5},
                  gap: 0, collide: 0, mid_start: 0, exp_mag: 16'd20, exp_idx: 3'd3, exp_det: 1};
      vecs[1] = '{s: {16'd5, 16'd12, 16'd12, 16'd2, 16'd12, 16'd0, 16'd1, 16'd3},
                  gap: 2, collide: 0, mid_start: 0, exp_mag: 16'd12, exp_idx: 3'd1, exp_det: 1};
      vecs[2] = '{s: {16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1},
                  gap: 0, collide: 1, mid_start: 1, exp_mag: 16'd1, exp_idx: 3'd0, exp_det: 0};
      vecs[3] = '{s: {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8},
                  gap: 0, collide: 0, mid_start: 0, exp_mag: 16'd8, exp_idx: 3'd7, exp_det: 0};
      vecs[4] = '{s: {16'd9, 16'd0, 16'd9, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0},
                  gap: 1, collide: 0, mid_start: 0, exp_mag: 16'd9, exp_idx: 3'd0, exp_det: 0};
      vecs[5] = '{s: {16'd1, 16'd10, 16'd10, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0},
                  gap: 0, collide: 0, mid_start: 0, exp_mag: 16'd10, exp_idx: 3'd1, exp_det: 1};
      vecs[6] = '{s: {16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7},
                  gap: 0, collide: 0, mid_start: 0, exp_mag: 16'd7, exp_idx: 3'd7, exp_det: 0};

      rst       = 1'b0;
      start     = 1'b0;
      mag_valid = 1'b0;
      mag_in    = '0;
`ifdef MAG_PEAK_THR_EN
      thr       = 16'd10;
`endif
      tick();
      tick();
      chk_reset_outputs("reset");
      rst = 1'b1;
      tick();

      // Table-driven windows, excluding the final reset-recovery vector.
      for (int k = 0; k < 6; k++) begin
         run_window(vecs[k], k, 1'b1);
         finish_window();
         tick();
      end

      // Reset mid-window after 4 samples discards the partial result.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mag_valid = 1'b1;
         mag_in    = 16'(100 + i);
         tick();
      end
      mag_valid = 1'b0;
      rst = 1'b0;
      tick();
      chk_reset_outputs("midreset");
      tick();
      chk_reset_outputs("midreset_hold");
      rst = 1'b1;
      tick();
      run_window(vecs[6], 6, 1'b1);
      finish_window();
      tick();

      // All-zero window, then start in the peak_valid cycle is ignored.
      begin
         vec_t z;
         z = '{s: '0, gap: 0, collide: 0, mid_start: 0, exp_mag: 16'd0, exp_idx: 3'd0, exp_det: 0};
         run_window(z, 7, 1'b1);
         chk("zero_idx_nonzero_prev", 32'(peak_idx), 32'd0);
         start = 1'b1;
         tick();
         start = 1'b0;
         chk("start_in_done_ignored", 32'(busy), 32'd0);
         chk("valid_dropped", 32'(peak_valid), 32'd0);
         start = 1'b1;
         tick();
         start = 1'b0;
         chk("start_after_done_accepted", 32'(busy), 32'd1);
         run_window(vecs[0], 8, 1'b0);
         finish_window();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
